button_bank: RTL and testbench



---
 rtl/button_bank_if.sv | 25 ++
 rtl/button_bank.sv | 145 ++++++++++++++
 tb/tb_button_bank.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/button_bank_if.sv
// Front-panel button bank signal group.
// The _i / _o suffixes are named from the debouncer's point of view.
interface button_bank_if #(
    parameter int CHANNELS = 4
);
    logic [CHANNELS-1:0] button_i;      // raw asynchronous pins
    logic [CHANNELS-1:0] clear_i;       // synchronous per-channel status clear
    logic [CHANNELS-1:0] pressed_o;     // debounced logical level
    logic [CHANNELS-1:0] press_o;       // one-cycle press pulse
    logic [CHANNELS-1:0] release_o;     // one-cycle release pulse
    logic [CHANNELS-1:0] long_press_o;  // one-cycle long-press pulse
    logic [CHANNELS-1:0] status_o;      // toggle latch or level

    // Board / control-register side: drives pins and clears, observes results.
    modport master (
        output button_i, clear_i,
        input  pressed_o, press_o, release_o, long_press_o, status_o
    );

    // Debouncer side.
    modport slave (
        input  button_i, clear_i,
        output pressed_o, press_o, release_o, long_press_o, status_o
    );
endinterface

// File: rtl/button_bank.sv
// Multi-channel push-button debouncer with press/release/long-press pulses
// and a per-channel status bit (press-toggled latch or debounced level).
module button_bank #(
    parameter int                  CHANNELS        = 4,
    parameter int                  CNT_W           = 16,
    parameter int                  DEBOUNCE_CYCLES = 50000,
    parameter int                  LONG_CYCLES     = 0,
    parameter int                  ACTIVE_LOW      = 1,
    parameter logic [CHANNELS-1:0] TOGGLE_MASK     = {CHANNELS{1'b1}},
    parameter logic [CHANNELS-1:0] INIT_STATUS     = {CHANNELS{1'b0}}
) (
    input  logic          clk,
    input  logic          reset,
    button_bank_if.slave  bus
);

    // Pin level while the button is not pressed.
    localparam logic             IDLE_LVL = (ACTIVE_LOW != 0);
    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam longint           CNT_SPAN = longint'(1) << CNT_W;
    localparam bit               CFG_OK   = (DEBOUNCE_CYCLES >= 1)
                                         && (CNT_SPAN > longint'(DEBOUNCE_CYCLES))
                                         && (CNT_SPAN > longint'(LONG_CYCLES));

    // Counters too narrow for the requested intervals would never terminate.
    always @(posedge clk) begin
        assert (CFG_OK) else $error("button_bank: CNT_W too narrow for DEBOUNCE_CYCLES/LONG_CYCLES");
    end

    genvar gi;
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
        localparam logic ST_RST = TOGGLE_MASK[gi] & INIT_STATUS[gi];

        logic             sync1_q, sync2_q;
        logic             raw;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             pressed_q, pressed_d;
        logic             press_q, release_q, long_q;
        logic             long_fired_q, long_fired_d;
        logic             status_q, status_d;
        logic             rise, fall, long_hit;

        // 1 = pressed, independent of pin polarity.
        assign raw  = sync2_q ^ IDLE_LVL;
        assign rise = pressed_d & ~pressed_q;
        assign fall = ~pressed_d & pressed_q;

        // Debounce: any matching sample restarts the run; a full run of
        // mismatches adopts the new level and restarts the counter.
        always_comb begin
            cnt_d     = '0;
            pressed_d = pressed_q;
            if (raw != pressed_q) begin
                if (cnt_q == DB_LAST) begin
                    pressed_d = raw;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        if (LONG_CYCLES > 0) begin : g_long
            localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(LONG_CYCLES);
            logic [CNT_W-1:0] hold_q, hold_d;

            // Hold timer: counts while held, saturates, clears when released.
            always_comb begin
                hold_d = '0;
                if (pressed_q) begin
                    hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + 1'b1;
                end
            end

            // Hold timer register.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    hold_q <= '0;
                end else begin
                    hold_q <= hold_d;
                end
            end

            // Fires only on the step into saturation, so never repeats.
            assign long_hit = pressed_q && (hold_q != HOLD_MAX) && (hold_d == HOLD_MAX);
        end else begin : g_no_long
            assign long_hit = 1'b0;
        end

        // Remember whether this hold already produced a long press.
        always_comb begin
            long_fired_d = long_fired_q;
            if (fall) begin
                long_fired_d = 1'b0;
            end else if (long_hit) begin
                long_fired_d = 1'b1;
            end
        end

        if (TOGGLE_MASK[gi]) begin : g_toggle
            // Toggle on a short-press release; clear overrides the toggle.
            always_comb begin
                status_d = status_q;
                if (bus.clear_i[gi]) begin
                    status_d = INIT_STATUS[gi];
                end else if (fall && !long_fired_q) begin
                    status_d = ~status_q;
                end
            end
        end else begin : g_level
            assign status_d = pressed_d;
        end

        // Channel state registers.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                sync1_q      <= IDLE_LVL;
                sync2_q      <= IDLE_LVL;
                cnt_q        <= '0;
                pressed_q    <= 1'b0;
                press_q      <= 1'b0;
                release_q    <= 1'b0;
                long_q       <= 1'b0;
                long_fired_q <= 1'b0;
                status_q     <= ST_RST;
            end else begin
                sync1_q      <= bus.button_i[gi];
                sync2_q      <= sync1_q;
                cnt_q        <= cnt_d;
                pressed_q    <= pressed_d;
                press_q      <= rise;
                release_q    <= fall;
                long_q       <= long_hit;
                long_fired_q <= long_fired_d;
                status_q     <= status_d;
            end
        end

        assign bus.pressed_o[gi]    = pressed_q;
        assign bus.press_o[gi]      = press_q;
        assign bus.release_o[gi]    = release_q;
        assign bus.long_press_o[gi] = long_q;
        assign bus.status_o[gi]     = status_q;
    end

endmodule

// File: tb/tb_button_bank.sv
// Bench for button_bank: directed test-plan sequences followed by random
// pin activity, all compared against a window/timestamp reference model.
module tb_button_bank;
    localparam int            CH = 4;
    localparam int            CW = 16;
    localparam int            DB = 4;
    localparam int            LC = 20;
    localparam logic [CH-1:0] TM = 4'b0011;
    localparam logic [CH-1:0] IS = 4'b0010;

    logic clk = 1'b0;
    logic reset;

    button_bank_if #(.CHANNELS(CH)) bus ();

    button_bank #(
        .CHANNELS(CH), .CNT_W(CW), .DEBOUNCE_CYCLES(DB), .LONG_CYCLES(LC),
        .ACTIVE_LOW(1), .TOGGLE_MASK(TM), .INIT_STATUS(IS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state.
    logic [DB+1:0] hist [CH];   // logical pin samples, newest in bit 0
    logic [CH-1:0] m_p, m_press, m_rel, m_long, m_stat, m_fired;
    int            rise_t [CH];
    int            cyc;

    task automatic check_vec(input string tag, input logic [CH-1:0] got, input logic [CH-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%b exp=%b t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            hist[c]   = '0;
            rise_t[c] = 0;
        end
        m_p = '0; m_press = '0; m_rel = '0; m_long = '0; m_fired = '0;
        m_stat = IS & TM;
        cyc = 0;
    endtask

    // One clock edge: pressed flips once the DB samples that reached the
    // debouncer (two edges old) all disagree with it.
    task automatic model_step(input logic [CH-1:0] btn, input logic [CH-1:0] clr);
        cyc++;
        for (int c = 0; c < CH; c++) begin
            logic old_p, new_p, all_diff, lhit;
            hist[c]  = {hist[c][DB:0], ~btn[c]};
            old_p    = m_p[c];
            all_diff = 1'b1;
            for (int j = 2; j < DB + 2; j++)
                if (hist[c][j] == old_p) all_diff = 1'b0;
            new_p      = all_diff ? ~old_p : old_p;
            m_press[c] = new_p & ~old_p;
            m_rel[c]   = ~new_p & old_p;
            lhit       = old_p && ((cyc - rise_t[c]) == LC);
            m_long[c]  = lhit;
            if (m_press[c]) rise_t[c] = cyc;
            if (TM[c]) begin
                if (clr[c])                     m_stat[c] = IS[c];
                else if (m_rel[c] && !m_fired[c]) m_stat[c] = ~m_stat[c];
            end else begin
                m_stat[c] = new_p;
            end
            if (m_rel[c])  m_fired[c] = 1'b0;
            else if (lhit) m_fired[c] = 1'b1;
            m_p[c] = new_p;
        end
    endtask

    task automatic compare_all(input string tag);
        check_vec({tag, "_pressed"}, bus.pressed_o,    m_p);
        check_vec({tag, "_press"},   bus.press_o,      m_press);
        check_vec({tag, "_release"}, bus.release_o,    m_rel);
        check_vec({tag, "_long"},    bus.long_press_o, m_long);
        check_vec({tag, "_status"},  bus.status_o,     m_stat);
    endtask

    // Drive inputs, take one edge, compare 1 time unit later.
    task automatic tick(input string tag, input logic [CH-1:0] btn, input logic [CH-1:0] clr);
        bus.button_i = btn;
        bus.clear_i  = clr;
        @(posedge clk);
        model_step(btn, clr);
        #1;
        compare_all(tag);
    endtask

    // Asynchronous reset asserted between edges, released one edge later.
    task automatic pulse_reset();
        #2 reset = 1'b1;
        #1;
        model_reset();
        compare_all("rst_async");
        @(posedge clk);
        #1;
        compare_all("rst_hold");
        reset = 1'b0;
    endtask

    initial begin
        logic [CH-1:0] btn_r, clr_r;
        int            dur [CH];

        reset        = 1'b1;
        bus.button_i = 4'hF;
        bus.clear_i  = 4'h0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        compare_all("reset");
        check_vec("reset_status_const", bus.status_o, 4'b0010);
        reset = 1'b0;

        // 1: press channel 0, exact 6-edge latency
        for (int i = 1; i <= 10; i++) begin
            tick("p1", 4'b1110, 4'b0000);
            if (i == 5) check_vec("lat_edge5", {3'b000, bus.pressed_o[0]}, 4'b0000);
            if (i == 6) check_vec("lat_edge6", {3'b000, bus.pressed_o[0]}, 4'b0001);
            if (i == 6) check_vec("press_edge6", {3'b000, bus.press_o[0]}, 4'b0001);
        end
        // 2: release, toggle, repeat
        repeat (10) tick("p2a", 4'b1111, 4'b0000);
        check_vec("toggle_on", {3'b000, bus.status_o[0]}, 4'b0001);
        repeat (10) tick("p2b", 4'b1110, 4'b0000);
        repeat (10) tick("p2c", 4'b1111, 4'b0000);
        check_vec("toggle_off", {3'b000, bus.status_o[0]}, 4'b0000);
        // 3: glitch on channel 1
        repeat (3) tick("p3a", 4'b1101, 4'b0000);
        repeat (6) tick("p3b", 4'b1111, 4'b0000);
        check_vec("glitch_status", bus.status_o, 4'b0010);
        // 4: long press on channel 0
        repeat (40) tick("p4a", 4'b1110, 4'b0000);
        repeat (10) tick("p4b", 4'b1111, 4'b0000);
        check_vec("long_no_toggle", {3'b000, bus.status_o[0]}, 4'b0000);
        // 5: level channel 2 with clear, then clear vs toggle on channel 1
        repeat (10) tick("p5a", 4'b1011, 4'b0100);
        check_vec("level_hi", {1'b0, bus.status_o[2], 2'b00}, 4'b0100);
        repeat (10) tick("p5b", 4'b1111, 4'b0100);
        repeat (10) tick("p5c", 4'b1101, 4'b0000);
        repeat (10) tick("p5d", 4'b1111, 4'b0010);
        check_vec("clear_wins", {2'b00, bus.status_o[1], 1'b0}, 4'b0010);
        // 6: reset mid-debounce on channel 3
        repeat (4) tick("p6a", 4'b0111, 4'b0000);
        pulse_reset();
        for (int i = 1; i <= 8; i++) begin
            tick("p6b", 4'b0111, 4'b0000);
            if (i == 5) check_vec("rst_lat5", {bus.pressed_o[3], 3'b000}, 4'b0000);
            if (i == 6) check_vec("rst_lat6", {bus.pressed_o[3], 3'b000}, 4'b1000);
        end

        // Random phase: mixed glitches, short and long holds, sparse clears.
        btn_r = 4'hF;
        for (int c = 0; c < CH; c++) dur[c] = 1;
        for (int i = 0; i < 2000; i++) begin
            for (int c = 0; c < CH; c++) begin
                if (dur[c] == 0) begin
                    btn_r[c] = ~btn_r[c];
                    dur[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 35))
                                                         : int'($urandom_range(1, 7));
                end
                dur[c]--;
                clr_r[c] = ($urandom_range(0, 15) == 0);
            end
            tick("rnd", btn_r, clr_r);
            if ((i % 500) == 499) pulse_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
